ieee1500_wsp_controller: RTL and testbench



---
 rtl/ieee1500_wsp_pkg.sv | 28 ++
 rtl/wsp_serdes.sv | 48 ++++
 rtl/ieee1500_wsp_controller.sv | 88 ++++++++
 tb/tb_ieee1500_wsp_controller.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ieee1500_wsp_pkg.sv
// ieee1500_wsp_pkg: shared constants, FSM states and command record for the IEEE 1500 WSP initiator
package ieee1500_wsp_pkg;

    localparam int WIR_LEN    = 3;
    localparam int MAX_DR_LEN = 16;
    localparam int LEN_W      = $clog2(MAX_DR_LEN + 1);

    localparam logic [WIR_LEN-1:0] BYPASS = 3'b000;
    localparam logic [WIR_LEN-1:0] EXTEST = 3'b001;
    localparam logic [WIR_LEN-1:0] INTEST = 3'b010;
    localparam logic [WIR_LEN-1:0] SAMPLE = 3'b011;
    localparam logic [WIR_LEN-1:0] CLAMP  = 3'b100;

    typedef enum logic [2:0] {IDLE, SELECT, CAPTURE, SHIFT, UPDATE, DESEL, RESP} wsp_state_t;

    typedef struct packed {
        logic                  is_ir;
        logic                  no_update;
        logic [LEN_W-1:0]      len;
        logic [MAX_DR_LEN-1:0] data;
    } wsp_cmd_t;

    // IR loads always shift the full WIR; DR lengths saturate at the data width
    function automatic logic [LEN_W-1:0] scan_len(input logic is_ir, input logic [LEN_W-1:0] len);
        return is_ir ? LEN_W'(WIR_LEN) : (len > LEN_W'(MAX_DR_LEN) ? LEN_W'(MAX_DR_LEN) : len);
    endfunction

endpackage

// File: rtl/wsp_serdes.sv
// wsp_serdes: wsi serialiser, wso deserialiser and shift bit counter for one WSP scan
module wsp_serdes
    import ieee1500_wsp_pkg::*;
(
    input  logic                  wrck,
    input  logic                  wrstn,
    input  logic                  load,
    input  logic                  adv,
    input  logic                  step,
    input  logic [MAX_DR_LEN-1:0] data,
    input  logic [LEN_W-1:0]      len,
    input  logic                  wso,
    output logic                  wsi,
    output logic [MAX_DR_LEN-1:0] rx,
    output logic                  last_bit
);

    localparam int IW = $clog2(MAX_DR_LEN);

    logic [MAX_DR_LEN-1:0] sh;
    logic [LEN_W-1:0]      cnt;

    assign last_bit = cnt == len - LEN_W'(1);

    // adv presents the next data bit on wsi for the coming shift cycle; step samples wso as it ends
    always_ff @(posedge wrck or negedge wrstn) begin
        if (!wrstn) begin
            sh  <= '0;
            rx  <= '0;
            cnt <= '0;
            wsi <= 1'b0;
        end else begin
            wsi <= adv & sh[0];
            if (load) begin
                sh  <= data;
                rx  <= '0;
                cnt <= '0;
            end else if (adv) begin
                sh <= sh >> 1;
            end
            if (step) begin
                rx[cnt[IW-1:0]] <= wso;
                cnt             <= last_bit ? '0 : cnt + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/ieee1500_wsp_controller.sv
// ieee1500_wsp_controller: WSP initiator sequencing WIR loads and WDR scans from a command stream
module ieee1500_wsp_controller
    import ieee1500_wsp_pkg::*;
(
    input  logic                  wrck,
    input  logic                  wrstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_is_ir,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  cmd_no_update,
    input  logic [MAX_DR_LEN-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MAX_DR_LEN-1:0] rsp_data,
    output logic                  busy,
    output logic                  wsi,
    input  logic                  wso,
    output logic                  selectwir,
    output logic                  capturewir,
    output logic                  shiftwir,
    output logic                  updatewir,
    output logic                  selectwdr,
    output logic                  capturewdr,
    output logic                  shiftwdr,
    output logic                  updatewdr
);

    wsp_state_t state, nxt;
    wsp_cmd_t   cmd;
    logic       accept, last_bit, ir_n;
    logic [3:0] ctl_n;

    assign accept = state == IDLE && cmd_valid && cmd_ready;
    assign ir_n   = accept ? cmd_is_ir : cmd.is_ir;
    assign ctl_n  = {nxt inside {SELECT, CAPTURE, SHIFT, UPDATE}, nxt == CAPTURE, nxt == SHIFT, nxt == UPDATE};

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? SELECT : IDLE;
            SELECT:  nxt = CAPTURE;
            CAPTURE: nxt = cmd.len != '0 ? SHIFT : (cmd.no_update ? DESEL : UPDATE);
            SHIFT:   nxt = !last_bit ? SHIFT : (cmd.no_update ? DESEL : UPDATE);
            UPDATE:  nxt = DESEL;
            DESEL:   nxt = RESP;
            RESP:    nxt = rsp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    // every output is a flop loaded from the next state, so the WSP sees glitch-free controls
    always_ff @(posedge wrck or negedge wrstn) begin
        if (!wrstn) begin
            state     <= IDLE;
            cmd       <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            {selectwir, capturewir, shiftwir, updatewir} <= '0;
            {selectwdr, capturewdr, shiftwdr, updatewdr} <= '0;
        end else begin
            state     <= nxt;
            cmd_ready <= nxt == IDLE;
            rsp_valid <= nxt == RESP;
            busy      <= nxt != IDLE;
            {selectwir, capturewir, shiftwir, updatewir} <= ir_n ? ctl_n : 4'b0;
            {selectwdr, capturewdr, shiftwdr, updatewdr} <= ir_n ? 4'b0 : ctl_n;
            if (accept)
                cmd <= '{cmd_is_ir, cmd_no_update, scan_len(cmd_is_ir, cmd_len), cmd_data};
        end
    end

    wsp_serdes u_serdes (
        .wrck     (wrck),
        .wrstn    (wrstn),
        .load     (state == SELECT),
        .adv      (nxt == SHIFT),
        .step     (state == SHIFT),
        .data     (cmd.data),
        .len      (cmd.len),
        .wso      (wso),
        .wsi      (wsi),
        .rx       (rsp_data),
        .last_bit (last_bit)
    );

endmodule

// File: tb/tb_ieee1500_wsp_controller.sv
// tb_ieee1500_wsp_controller: directed checks of the WSP controller against a small 1500 wrapper model
module tb_ieee1500_wsp_controller;
    import ieee1500_wsp_pkg::*;

    logic                  wrck = 1'b0, wrstn = 1'b0;
    logic                  cmd_valid = 1'b0, cmd_ready, cmd_is_ir = 1'b0, cmd_no_update = 1'b0;
    logic [LEN_W-1:0]      cmd_len = '0;
    logic [MAX_DR_LEN-1:0] cmd_data = '0, rsp_data;
    logic                  rsp_valid, rsp_ready = 1'b1, busy, wsi, wso;
    logic                  selectwir, capturewir, shiftwir, updatewir;
    logic                  selectwdr, capturewdr, shiftwdr, updatewdr;

    int total = 0, bad = 0;
    int n_sel, n_cap, n_shift, n_upd, n_wrong;
    logic [15:0] wsi_log;

    ieee1500_wsp_controller dut (
        .wrck(wrck), .wrstn(wrstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_no_update(cmd_no_update), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
        .wsi(wsi), .wso(wso),
        .selectwir(selectwir), .capturewir(capturewir), .shiftwir(shiftwir), .updatewir(updatewir),
        .selectwdr(selectwdr), .capturewdr(capturewdr), .shiftwdr(shiftwdr), .updatewdr(updatewdr)
    );

    always #5 wrck = ~wrck;

    // wrapper model: 3-bit WIR, non-capturing 1-bit bypass, 16-bit boundary register {core_in, core_out}
    logic [2:0]  wir, wir_sh;
    logic        byp;
    logic [15:0] bsr, upd;
    logic [7:0]  core_out;

    always @(posedge wrck or negedge wrstn) begin
        if (!wrstn) begin
            wir <= BYPASS; wir_sh <= '0; byp <= 1'b0; bsr <= '0; upd <= '0;
        end else begin
            if (capturewir) wir_sh <= wir;
            if (shiftwir) wir_sh <= {wsi, wir_sh[2:1]};
            if (updatewir) wir <= wir_sh;
            if (wir == BYPASS && shiftwdr) byp <= wsi;
            if (wir != BYPASS && capturewdr) bsr <= {8'hC3, upd[7:0]};
            if (wir != BYPASS && shiftwdr) bsr <= {wsi, bsr[15:1]};
            if (wir != BYPASS && updatewdr) upd <= bsr;
        end
    end

    assign wso      = selectwir ? wir_sh[0] : (wir == BYPASS ? byp : bsr[0]);
    assign core_out = upd[7:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // issue one command from a negedge, watch the scan, then complete the response handshake
    task automatic do_cmd(input string tag, input logic ir, input logic [LEN_W-1:0] len, input logic nu,
                          input logic [15:0] d, input int stall, input logic [15:0] exp_rsp, input int exp_lat);
        int w, e, le;
        logic [3:0] g, o;
        logic [31:0] m;
        le = ir ? 3 : (int'(len) > 16 ? 16 : int'(len));
        m  = (32'd1 << le) - 32'd1;
        cmd_valid = 1'b1; cmd_is_ir = ir; cmd_len = len; cmd_no_update = nu; cmd_data = d;
        rsp_ready = (stall == 0);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge wrck);
            w++;
        end
        check({tag, "_acc"}, 32'(cmd_ready), 32'd1);
        @(posedge wrck);
        @(negedge wrck);
        cmd_valid = 1'b0;
        n_sel = 0; n_cap = 0; n_shift = 0; n_upd = 0; n_wrong = 0; wsi_log = '0; e = 0;
        while (!rsp_valid && e < 60) begin
            g = ir ? {selectwir, capturewir, shiftwir, updatewir} : {selectwdr, capturewdr, shiftwdr, updatewdr};
            o = ir ? {selectwdr, capturewdr, shiftwdr, updatewdr} : {selectwir, capturewir, shiftwir, updatewir};
            n_sel += int'(g[3]); n_cap += int'(g[2]); n_upd += int'(g[0]);
            if (g[1]) begin
                if (n_shift < 16) wsi_log[n_shift] = wsi;
                n_shift++;
            end
            n_wrong += int'(|o) + int'(cmd_ready);
            @(negedge wrck);
            e++;
        end
        check({tag, "_lat"}, 32'(e), 32'(exp_lat));
        check({tag, "_rsp"}, 32'(rsp_data), 32'(exp_rsp));
        check({tag, "_wsi"}, 32'(wsi_log), 32'(d) & m);
        check({tag, "_nshift"}, 32'(n_shift), 32'(le));
        check({tag, "_ncap_nupd"}, 32'({n_cap[7:0], n_upd[7:0]}), 32'({8'd1, 8'(nu ? 0 : 1)}));
        check({tag, "_nsel"}, 32'(n_sel), 32'(2 + le + (nu ? 0 : 1)));
        check({tag, "_other_grp"}, 32'(n_wrong), 32'd0);
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'b1;
            check({tag, "_hold"}, 32'({rsp_valid, cmd_ready, busy}), 32'b101);
            check({tag, "_hold_data"}, 32'(rsp_data), 32'(exp_rsp));
            @(negedge wrck);
        end
        rsp_ready = 1'b1;
        @(posedge wrck);
        @(negedge wrck);
        check({tag, "_done"}, 32'({rsp_valid, cmd_ready, busy}), 32'b010);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #3;
        check("reset_outs", 32'({selectwir, capturewir, shiftwir, updatewir, selectwdr, capturewdr,
                                 shiftwdr, updatewdr, wsi, rsp_valid, busy, cmd_ready}), 32'd0);
        check("reset_data", 32'(rsp_data), 32'd0);
        @(negedge wrck);
        wrstn = 1'b1;
        @(negedge wrck);
        check("post_reset_ready", 32'({cmd_ready, busy}), 32'b10);

        do_cmd("ir_extest", 1'b1, 5'd0, 1'b0, 16'h0001, 0, 16'h0000, 7);
        do_cmd("dr_a55a", 1'b0, 5'd16, 1'b0, 16'hA55A, 0, 16'hC300, 20);
        check("core_out_a55a", 32'(core_out), 32'h5A);
        do_cmd("dr_ro", 1'b0, 5'd16, 1'b1, 16'h0000, 0, 16'hC35A, 19);
        check("core_out_ro", 32'(core_out), 32'h5A);
        do_cmd("ir_bypass", 1'b1, 5'd0, 1'b0, 16'h0000, 0, 16'h0001, 7);
        do_cmd("byp_1", 1'b0, 5'd1, 1'b0, 16'h0001, 0, 16'h0000, 5);
        do_cmd("byp_0", 1'b0, 5'd1, 1'b0, 16'h0000, 0, 16'h0001, 5);
        do_cmd("len0", 1'b0, 5'd0, 1'b0, 16'hFFFF, 0, 16'h0000, 4);
        do_cmd("len20", 1'b0, 5'd20, 1'b0, 16'h8001, 0, 16'h0002, 20);
        do_cmd("stall", 1'b0, 5'd1, 1'b0, 16'h0001, 5, 16'h0001, 5);

        cmd_valid = 1'b1; cmd_is_ir = 1'b0; cmd_len = 5'd16; cmd_no_update = 1'b0; cmd_data = 16'hFFFF;
        check("rst_scan_acc", 32'(cmd_ready), 32'd1);
        @(posedge wrck);
        @(negedge wrck);
        cmd_valid = 1'b0;
        repeat (9) @(negedge wrck);
        check("rst_at_bit7", 32'({shiftwdr, selectwdr, rsp_data[5]}), 32'b111);
        #2 wrstn = 1'b0;
        #1;
        check("rst_async_outs", 32'({selectwir, capturewir, shiftwir, updatewir, selectwdr, capturewdr,
                                     shiftwdr, updatewdr, wsi, rsp_valid, busy}), 32'd0);
        check("rst_async_data", 32'(rsp_data), 32'd0);
        @(posedge wrck);
        @(negedge wrck);
        wrstn = 1'b1;
        @(negedge wrck);
        check("rst_release", 32'({cmd_ready, rsp_valid, busy}), 32'b100);
        do_cmd("ir_sample", 1'b1, 5'd0, 1'b0, 16'h0003, 0, 16'h0000, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
